// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: instruction port, data port and SRAM port.
// The master modport is the environment (requesters plus the SRAM);
// the slave modport is the arbiter itself.
interface mem_port_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata,
        output sram_rdata
    );

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata,
        input  sram_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-cycle SRAM between an instruction
// fetch port and a data load/store port. One request is accepted per cycle
// and its response returns exactly one cycle later, with no back-pressure.
// Default policy: data always wins over inst.
// Optional macro MEM_PORT_ARB_RR_EN: alternate on simultaneous requests,
// using a 1-bit last_grant register (reset to inst, so data wins first).
module mem_port_arbiter (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.slave    bus
);

    logic grant_inst;
    logic grant_data;
    logic grant_any;
    logic resp_valid;
    logic resp_owner;

`ifdef MEM_PORT_ARB_RR_EN
    logic last_grant;
`endif

    // Pick at most one requester this cycle; nothing is granted during reset.
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (!reset) begin
`ifdef MEM_PORT_ARB_RR_EN
            if (bus.data_req && bus.inst_req) begin
                grant_data = !last_grant;
                grant_inst = last_grant;
            end else begin
                grant_data = bus.data_req;
                grant_inst = bus.inst_req;
            end
`else
            grant_data = bus.data_req;
            grant_inst = bus.inst_req && !bus.data_req;
`endif
        end
    end

    assign grant_any = grant_inst || grant_data;

    // Steer the granted request onto the SRAM in the same cycle; idle bus is all zero.
    always_comb begin
        bus.sram_en    = 1'b0;
        bus.sram_we    = 4'b0000;
        bus.sram_addr  = 32'h0;
        bus.sram_wdata = bus.data_wdata;
        if (grant_data) begin
            bus.sram_en   = 1'b1;
            bus.sram_addr = bus.data_addr;
            bus.sram_we   = bus.data_wr ? bus.data_wstrb : 4'b0000;
        end else if (grant_inst) begin
            bus.sram_en   = 1'b1;
            bus.sram_addr = bus.inst_addr;
        end
    end

    // Remember who was granted so the response is routed one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_owner <= 1'b0;
        end else begin
            resp_valid <= grant_any;
            resp_owner <= grant_data;
        end
    end

`ifdef MEM_PORT_ARB_RR_EN
    // Track the most recent winner; only an actual grant moves the pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b0;
        end else if (grant_any) begin
            last_grant <= grant_data;
        end
    end
`endif

    // Handshake outputs. data_ok is masked during reset so a response owed
    // from the cycle before reset never shows up.
    assign bus.inst_addr_ok = grant_inst;
    assign bus.data_addr_ok = grant_data;
    assign bus.inst_data_ok = !reset && resp_valid && !resp_owner;
    assign bus.data_data_ok = !reset && resp_valid && resp_owner;
    assign bus.inst_rdata   = bus.sram_rdata;
    assign bus.data_rdata   = bus.sram_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by random
// traffic, every cycle compared against a behavioural reference model.
module tb_mem_port_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    // Reference model state: who won the last accepted grant (0 inst, 1 data)
    // and the response owed next cycle (-1 none, 0 inst, 1 data).
    int   model_last_winner;
    int   model_owed;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, then check the
    // outputs mid-cycle against the model and advance the model.
    task automatic applyStimulus(input logic rst,
                                 input logic ireq, input logic [31:0] iaddr,
                                 input logic dreq, input logic dwr,
                                 input logic [3:0] strb, input logic [31:0] daddr,
                                 input logic [31:0] wdata, input logic [31:0] rdata);
        int winner;
        logic [3:0] exp_we;
        logic [31:0] exp_addr;
        @(posedge clk);
        #1;
        reset          = rst;
        bus.inst_req   = ireq;
        bus.inst_addr  = iaddr;
        bus.data_req   = dreq;
        bus.data_wr    = dwr;
        bus.data_wstrb = strb;
        bus.data_addr  = daddr;
        bus.data_wdata = wdata;
        bus.sram_rdata = rdata;
        #3;

        winner = -1;
        if (!rst) begin
            if (dreq && ireq) begin
`ifdef MEM_PORT_ARB_RR_EN
                winner = (model_last_winner == 1) ? 0 : 1;
`else
                winner = 1;
`endif
            end else if (dreq) begin
                winner = 1;
            end else if (ireq) begin
                winner = 0;
            end
        end

        exp_we   = 4'b0000;
        exp_addr = 32'h0;
        if (winner == 1) begin
            exp_addr = daddr;
            exp_we   = dwr ? strb : 4'b0000;
        end else if (winner == 0) begin
            exp_addr = iaddr;
        end

        checkOutput("inst_addr_ok", {31'h0, bus.inst_addr_ok}, {31'h0, winner == 0});
        checkOutput("data_addr_ok", {31'h0, bus.data_addr_ok}, {31'h0, winner == 1});
        checkOutput("sram_en", {31'h0, bus.sram_en}, {31'h0, winner != -1});
        checkOutput("sram_we", {28'h0, bus.sram_we}, {28'h0, exp_we});
        checkOutput("sram_addr", bus.sram_addr, exp_addr);
        if (winner == 1)
            checkOutput("sram_wdata", bus.sram_wdata, wdata);
        checkOutput("inst_data_ok", {31'h0, bus.inst_data_ok},
                    {31'h0, !rst && model_owed == 0});
        checkOutput("data_data_ok", {31'h0, bus.data_data_ok},
                    {31'h0, !rst && model_owed == 1});
        if (!rst && model_owed == 0)
            checkOutput("inst_rdata", bus.inst_rdata, rdata);
        if (!rst && model_owed == 1)
            checkOutput("data_rdata", bus.data_rdata, rdata);

        if (rst) begin
            model_last_winner = 0;
            model_owed        = -1;
        end else begin
            model_owed = winner;
            if (winner != -1)
                model_last_winner = winner;
        end
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        model_last_winner = 0;
        model_owed        = -1;
        reset             = 1'b1;
        bus.inst_req      = 1'b0;
        bus.inst_addr     = 32'h0;
        bus.data_req      = 1'b0;
        bus.data_wr       = 1'b0;
        bus.data_wstrb    = 4'h0;
        bus.data_addr     = 32'h0;
        bus.data_wdata    = 32'h0;
        bus.sram_rdata    = 32'h0;

        // Reset with both requesters active: everything must stay zero.
        applyStimulus(1, 1, 32'h40, 1, 1, 4'hF, 32'h80, 32'h1234, 32'h0);
        applyStimulus(1, 1, 32'h40, 1, 0, 4'hF, 32'h80, 32'h1234, 32'h0);

        // Instruction fetch right after reset, response next cycle.
        applyStimulus(0, 1, 32'h1C000000, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        applyStimulus(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h02800C0C);

        // Partial store then its write acknowledge.
        applyStimulus(0, 0, 32'h0, 1, 1, 4'b0011, 32'h100, 32'hDEADBEEF, 32'h0);
        applyStimulus(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h55AA55AA);

        // Both requesters held for four cycles.
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 1, 32'h2000 + 32'(i * 4), 1, 0, 4'hF,
                          32'h3000 + 32'(i * 4), 32'h0, 32'hA0000000 + 32'(i));
        applyStimulus(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 32'hA0000004);

        // Back-to-back instruction loads.
        applyStimulus(0, 1, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        applyStimulus(0, 1, 32'h4, 0, 0, 4'h0, 32'h0, 32'h0, 32'h11111111);
        applyStimulus(0, 1, 32'h8, 0, 0, 4'h0, 32'h0, 32'h0, 32'h22222222);
        applyStimulus(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h33333333);

        // Data load accepted, then reset: the owed response must vanish.
        applyStimulus(0, 0, 32'h0, 1, 0, 4'hF, 32'h500, 32'h0, 32'h0);
        applyStimulus(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h77777777);
        applyStimulus(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h88888888);

        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++)
            applyStimulus(($urandom_range(0, 24) == 0),
                          1'($urandom_range(0, 2) != 0), $urandom,
                          1'($urandom_range(0, 2) != 0), 1'($urandom),
                          4'($urandom), $urandom, $urandom, $urandom);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have these ports: clk  in  1  clock; reset  in  1  synchronous, active-high reset.
REQ-002 The block SHALL have these instruction-side ports: inst_req  in  1  fetch request; inst_addr  in  32  fetch address; inst_addr_ok  out  1  request accepted; inst_data_ok  out  1  response valid; inst_rdata  out  32  read data.
REQ-003 The block SHALL have these data-side ports: data_req  in  1  request; data_wr  in  1  1=store; data_wstrb  in  4  byte enables; data_addr  in  32  address; data_wdata  in  32  store data; data_addr_ok  out  1  accepted; data_data_ok  out  1  response valid; data_rdata  out  32  read data.
REQ-004 The block SHALL have these SRAM ports: sram_en  out  1  access enable; sram_we  out  4  byte write enables; sram_addr  out  32  address; sram_wdata  out  32  write data; sram_rdata  in  32  read data, valid one cycle after sram_en.

Function
REQ-005 A request SHALL be accepted in the cycle where X_req && X_addr_ok, where X is inst or data; at most one requester SHALL be accepted per cycle.
REQ-006 addr_ok SHALL be combinational from the current req inputs and arbitration state, and SHALL be low while reset is high.
REQ-007 Default policy: data SHALL have fixed priority over inst; inst_addr_ok = inst_req && !data_req.
REQ-008 The granted request SHALL drive the SRAM in the same cycle: sram_en=1, sram_addr=granted addr, sram_we=data_wr ? data_wstrb : 4'b0 for data, and 4'b0 for inst, sram_wdata=data_wdata.
REQ-009 With no grant, the block SHALL drive sram_en=0, sram_we=0, and sram_addr=0.
REQ-010 Response tracking SHALL use registers resp_valid and resp_owner (0=inst, 1=data), loaded every cycle with {grant_any, grant_is_data}.
REQ-011 X_data_ok SHALL equal resp_valid && resp_owner==X, which is exactly one cycle after acceptance; latency SHALL be fixed at 1 cycle.
REQ-012 inst_rdata and data_rdata SHALL both equal sram_rdata; they are meaningful only when the matching data_ok is high.
REQ-013 Stores SHALL also produce data_data_ok one cycle after acceptance as a write acknowledge; data_rdata is don't-care in that case.
REQ-014 Requesters SHALL accept data_ok unconditionally, so the block has no response back-pressure.
REQ-015 The block SHALL support back-to-back accepts, one per cycle: a new grant and the previous response SHALL coexist in the same cycle.
REQ-016 A request that is not accepted SHALL be held by the requester; the block SHALL neither queue nor drop state for it.
REQ-017 A request accepted in the cycle before reset SHALL produce no data_ok after reset.

Reset
REQ-018 While reset is high, the block SHALL clear resp_valid, resp_owner, and the round-robin pointer.
REQ-019 While reset is high, all outputs SHALL be 0: inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, sram_en, sram_we, sram_addr.
REQ-020 The first cycle after reset SHALL be able to accept a request.

Configuration
REQ-021 The block SHALL provide macro MEM_PORT_ARB_RR_EN; when it is undefined, the fixed data priority of REQ-007 SHALL apply.
REQ-022 When MEM_PORT_ARB_RR_EN is defined, the block SHALL keep a 1-bit register last_grant (reset 0 = inst, so data wins first).
REQ-023 Under MEM_PORT_ARB_RR_EN, on simultaneous requests the requester that is not last_grant SHALL win; last_grant SHALL update only on an accepted grant.
REQ-024 Under MEM_PORT_ARB_RR_EN, a single requester SHALL always be granted immediately.

Verification
REQ-025 Scenario: inst_req=1, addr=0x1C000000, sram_rdata next cycle=0x02800C0C -> inst_addr_ok=1 in cycle 0; inst_data_ok=1 with inst_rdata=0x02800C0C in cycle 1; data_data_ok=0 throughout.
REQ-026 Scenario: data store with addr=0x100, wstrb=4'b0011, wdata=0xDEADBEEF -> sram_we=4'b0011, sram_addr=0x100, sram_wdata=0xDEADBEEF in the accept cycle; data_data_ok=1 the next cycle.
REQ-027 Scenario: both requesters held high for 4 cycles, macro undefined -> data granted in all 4 cycles; inst_addr_ok=0; four data_data_ok pulses, each lagging its grant by 1.
REQ-028 Scenario: the same stimulus with MEM_PORT_ARB_RR_EN defined -> grants alternate data, inst, data, inst; responses go to the matching owner each following cycle.
REQ-029 Scenario: back-to-back inst loads of 0x0, 0x4, 0x8 -> three consecutive addr_ok cycles, then three consecutive inst_data_ok cycles with rdata in order.
REQ-030 Scenario: data load accepted, then reset asserted the next cycle -> no data_data_ok is observed, and all outputs are 0 during reset.
